prien_arb: RTL and testbench

- Parametrised N-input priority encoder with a registered output and a grant/acknowledge handshake.
- Supports two modes: fixed priority (highest index wins) and round-robin priority.
- Captures the winning request index and a one-hot grant, and holds them until the consumer acknowledges.
- Used wherever several requesters share one resource and the plain combinational 8:3 encoder cannot provide fairness or hold a grant.

---
 rtl/prien_arb.sv | 110 +++++++++++
 tb/tb_prien_arb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/prien_arb.sv
// N-input priority arbiter with registered grant held until acknowledged; fixed or round-robin priority.
// Optional PRIEN_ARB_MULTI_EN adds a registered 'multi' flag (more than one request at capture).
module prien_arb #(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         mode,
   input  logic [N-1:0] a,
   input  logic         ack,
   output logic [W-1:0] y,
   output logic [N-1:0] g,
`ifdef PRIEN_ARB_MULTI_EN
   output logic         multi,
`endif
   output logic         valid
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t       r_state;
   logic [W-1:0] r_y;
   logic [N-1:0] r_g;
   logic         r_valid;
   logic [W-1:0] r_ptr;
   logic         r_mode;

   logic [W-1:0] w_start;
   logic [W-1:0] w_win;
   logic [N-1:0] w_onehot;
   logic         w_found;
   int           w_idx;

   // Fixed priority is round-robin search starting from N-1; index math wraps modulo N.
   always_comb begin
      w_start = mode ? r_ptr : W'(N - 1);
      w_win   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < N; k++) begin
         w_idx = int'(w_start) - k;
         if (w_idx < 0) w_idx = w_idx + N;
         if (!w_found && a[w_idx]) begin
            w_win   = W'(w_idx);
            w_found = 1'b1;
         end
      end
      w_onehot = N'(1) << w_win;
   end

`ifdef PRIEN_ARB_MULTI_EN
   logic r_multi;
   logic w_multi;

   assign w_multi = |(a & (a - N'(1)));
   assign multi   = r_multi;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_multi <= 1'b0;
      end else if (r_state == S_IDLE && en && (|a)) begin
         r_multi <= w_multi;
      end else if (r_state == S_GRANT && ack) begin
         r_multi <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_y     <= '0;
         r_g     <= '0;
         r_valid <= 1'b0;
         r_ptr   <= W'(N - 1);
         r_mode  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_valid <= 1'b0;
               if (en && (|a)) begin
                  r_y     <= w_win;
                  r_g     <= w_onehot;
                  r_valid <= 1'b1;
                  r_mode  <= mode;
                  r_state <= S_GRANT;
               end
            end
            S_GRANT: begin
               // The grant is latched: request, enable and mode are ignored until ack.
               if (ack) begin
                  r_valid <= 1'b0;
                  r_g     <= '0;
                  r_state <= S_IDLE;
                  if (r_mode)
                     r_ptr <= (r_y == '0) ? W'(N - 1) : r_y - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign y     = r_y;
   assign g     = r_g;
   assign valid = r_valid;

endmodule

// File: tb/tb_prien_arb.sv
// Directed table-driven bench for prien_arb (N=8 and N=5 instances), plus async-reset and multi sequences.
module tb_prien_arb;

   typedef struct {
      logic       en;
      logic       mode;
      logic [7:0] a;
      logic       ack;
      logic       v;
      logic [2:0] y;
      logic [7:0] g;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en8 = 1'b0, mode8 = 1'b0, ack8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [2:0] y8;
   logic [7:0] g8;
   logic       valid8;
   logic       en5 = 1'b0, mode5 = 1'b0, ack5 = 1'b0;
   logic [4:0] a5 = '0;
   logic [2:0] y5;
   logic [4:0] g5;
   logic       valid5;
`ifdef PRIEN_ARB_MULTI_EN
   logic       multi8, multi5;
`endif

   int total = 0;
   int bad   = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   prien_arb #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .en(en8), .mode(mode8), .a(a8), .ack(ack8),
      .y(y8), .g(g8),
`ifdef PRIEN_ARB_MULTI_EN
      .multi(multi8),
`endif
      .valid(valid8)
   );

   prien_arb #(.N(5)) dut5 (
      .clk(clk), .rst(rst), .en(en5), .mode(mode5), .a(a5), .ack(ack5),
      .y(y5), .g(g5),
`ifdef PRIEN_ARB_MULTI_EN
      .multi(multi5),
`endif
      .valid(valid5)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic e, input logic m, input logic [7:0] av, input logic k,
                               input logic v, input logic [2:0] yy, input logic [7:0] gg);
      vec_t t;
      t.en = e; t.mode = m; t.a = av; t.ack = k; t.v = v; t.y = yy; t.g = gg;
      tbl.push_back(t);
   endfunction

   initial begin
      // fixed priority, twice
      add(1, 0, 8'hC2, 0, 1, 7, 8'h80);
      add(1, 0, 8'hC2, 1, 0, 7, 8'h00);
      add(1, 0, 8'hC2, 0, 1, 7, 8'h80);
      add(1, 0, 8'hC2, 1, 0, 7, 8'h00);
      // round-robin full load, ack held high (ignored in IDLE)
      for (int i = 7; i >= 0; i--) begin
         add(1, 1, 8'hFF, 1, 1, 3'(i), 8'(1) << i);
         add(1, 1, 8'hFF, 1, 0, 3'(i), 8'h00);
      end
      add(1, 1, 8'hFF, 1, 1, 7, 8'h80);
      add(1, 1, 8'hFF, 1, 0, 7, 8'h00);
      // round-robin sparse from ptr=6, then fixed
      add(1, 1, 8'h24, 1, 1, 5, 8'h20); add(1, 1, 8'h24, 1, 0, 5, 8'h00);
      add(1, 1, 8'h24, 1, 1, 2, 8'h04); add(1, 1, 8'h24, 1, 0, 2, 8'h00);
      add(1, 1, 8'h24, 1, 1, 5, 8'h20); add(1, 1, 8'h24, 1, 0, 5, 8'h00);
      add(1, 1, 8'h24, 1, 1, 2, 8'h04); add(1, 1, 8'h24, 1, 0, 2, 8'h00);
      add(1, 0, 8'h24, 1, 1, 5, 8'h20); add(1, 0, 8'h24, 1, 0, 5, 8'h00);
      add(1, 0, 8'h24, 1, 1, 5, 8'h20); add(1, 0, 8'h24, 1, 0, 5, 8'h00);
      // empty request, disabled, then held grant with changing inputs
      for (int i = 0; i < 4; i++) add(1, 0, 8'h00, 0, 0, 5, 8'h00);
      add(0, 0, 8'hFF, 0, 0, 5, 8'h00);
      add(1, 0, 8'h08, 0, 1, 3, 8'h08);
      add(1, 1, 8'h01, 0, 1, 3, 8'h08);
      add(0, 0, 8'h01, 0, 1, 3, 8'h08);
      add(1, 1, 8'h01, 0, 1, 3, 8'h08);
      add(1, 0, 8'h00, 1, 0, 3, 8'h00);

      // reset state
      #3;
      chk("rst_valid8", 32'(valid8), 0);
      chk("rst_y8", 32'(y8), 0);
      chk("rst_g8", 32'(g8), 0);
      chk("rst_valid5", 32'(valid5), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      foreach (tbl[i]) begin
         en8 = tbl[i].en; mode8 = tbl[i].mode; a8 = tbl[i].a; ack8 = tbl[i].ack;
         step();
         chk($sformatf("vec%0d_valid", i), 32'(valid8), 32'(tbl[i].v));
         chk($sformatf("vec%0d_y", i), 32'(y8), 32'(tbl[i].y));
         chk($sformatf("vec%0d_g", i), 32'(g8), 32'(tbl[i].g));
      end

      // async reset mid-grant (ptr is 1 here, so a post-reset y=7 proves ptr reset)
      en8 = 1; mode8 = 0; a8 = 8'h20; ack8 = 0;
      step();
      chk("pre_rst_y", 32'(y8), 5);
      chk("pre_rst_valid", 32'(valid8), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(valid8), 0);
      chk("async_rst_g", 32'(g8), 0);
      chk("async_rst_y", 32'(y8), 0);
      @(negedge clk);
      rst = 1'b0;
      mode8 = 1; a8 = 8'hFF;
      step();
      chk("post_rst_y", 32'(y8), 7);
      chk("post_rst_valid", 32'(valid8), 1);
      ack8 = 1;
      step();
      chk("post_rst_ack_valid", 32'(valid8), 0);
      en8 = 0; ack8 = 0;

      // N=5 round-robin wrap
      en5 = 1; mode5 = 1; a5 = 5'b11111; ack5 = 1;
      for (int k = 0; k < 6; k++) begin
         automatic int ey = (k == 5) ? 4 : 4 - k;
         step();
         chk($sformatf("n5_%0d_valid", k), 32'(valid5), 1);
         chk($sformatf("n5_%0d_y", k), 32'(y5), 32'(ey));
         chk($sformatf("n5_%0d_g", k), 32'(g5), 32'(5'(1) << ey));
         chk($sformatf("n5_%0d_yrange", k), 32'(y5 < 3'd5), 1);
         step();
         chk($sformatf("n5_%0d_bubble", k), 32'(valid5), 0);
      end

`ifdef PRIEN_ARB_MULTI_EN
      // ptr=3 now: 10001 -> y=0, then ptr=4: 00100 -> y=2
      a5 = 5'b10001; ack5 = 0;
      step();
      chk("multi_y0", 32'(y5), 0);
      chk("multi_set", 32'(multi5), 1);
      ack5 = 1;
      step();
      chk("multi_clr", 32'(multi5), 0);
      a5 = 5'b00100; ack5 = 0;
      step();
      chk("multi_y2", 32'(y5), 2);
      chk("multi_single", 32'(multi5), 0);
      chk("multi_valid", 32'(valid5), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
